// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST forward/training datapath: sizes, weight row type,
// forward FSM states and the class-index to digit mapping.
package nn_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_CLASSES = 10;
  localparam int ADDR_W      = 10;

  typedef logic [NUM_CLASSES-1:0][15:0] weight_row_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    ARGMAX,
    DONE
  } fwd_state_t;

  // Class index 9 is digit 0, index 0 is digit 9.
  function automatic logic [3:0] class_to_digit(input logic [3:0] idx);
    return 4'd9 - idx;
  endfunction

endpackage

// File: rtl/argmax_seq.sv
// Sequential max-index scanner: one element per cycle from index N-1 down to 0.
// Ties keep the earlier (higher) index; done_o and idx_o are valid in the last scan cycle.
module argmax_seq
  import nn_pkg::*;
#(
  parameter int N = NUM_CLASSES,
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [N-1:0][W-1:0]       values_i,
  output logic                      done_o,
  output logic [$clog2(N)-1:0]      idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       scan_idx;
  logic [IW-1:0]       best_idx_q;
  logic [IW-1:0]       best_idx_d;
  logic signed [W-1:0] best_q;
  logic signed [W-1:0] best_d;
  logic signed [W-1:0] cand;
  logic                run_q;
  logic                take;

  always_comb begin
    scan_idx   = start_i ? IW'(N - 1) : idx_q;
    cand       = $signed(values_i[scan_idx]);
    // The first element is taken unconditionally; later ones must be strictly greater.
    take       = start_i || (cand > best_q);
    best_d     = take ? cand : best_q;
    best_idx_d = take ? scan_idx : best_idx_q;
    done_o     = (start_i || run_q) && (scan_idx == '0);
    idx_o      = best_idx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      if (start_i) begin
        run_q <= 1'b1;
        idx_q <= IW'(N - 2);
      end else if (run_q) begin
        idx_q <= idx_q - IW'(1);
        if (idx_q == '0) run_q <= 1'b0;
      end
      if (start_i || run_q) begin
        best_q     <= best_d;
        best_idx_q <= best_idx_d;
      end
    end
  end

endmodule

// File: rtl/forward_accumulate.sv
// Forward pass for the single-layer MNIST classifier: accumulates weight rows of set pixels,
// then picks the winning class. Optional macro FWD_SATURATE_EN clamps scores instead of truncating.
module forward_accumulate
  import nn_pkg::*;
#(
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_pixel,
  input  logic        start_stream,
  input  logic        pixel,
  output logic [9:0]  rd_addr,
  input  weight_row_t weights_in,
  output weight_row_t output_test,
  output logic [3:0]  digit,
  output logic        result_valid,
  output logic        busy
);

  localparam logic [9:0] LAST_PIX = 10'(NUM_PIXELS - 1);

  fwd_state_t                        state_q;
  logic [9:0]                        count_q;
  logic                              pix_q;
  logic                              vld_q;
  logic                              am_start_q;
  logic [NUM_CLASSES-1:0][ACC_W-1:0] acc_q;
  logic [NUM_CLASSES-1:0][ACC_W-1:0] cmp_vals;
  weight_row_t                       out_conv;
  weight_row_t                       output_test_q;
  logic [3:0]                        digit_q;
  logic                              result_valid_q;
  logic                              am_done;
  logic [3:0]                        am_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_conv
`ifdef FWD_SATURATE_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
      localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);
      assign out_conv[gi] = ($signed(acc_q[gi]) > SAT_MAX) ? 16'h7fff :
                            ($signed(acc_q[gi]) < SAT_MIN) ? 16'h8000 : acc_q[gi][15:0];
      assign cmp_vals[gi] = {{(ACC_W-16){out_conv[gi][15]}}, out_conv[gi]};
`else
      assign out_conv[gi] = acc_q[gi][15:0];
      assign cmp_vals[gi] = acc_q[gi];
`endif
    end
  endgenerate

  argmax_seq #(.N(NUM_CLASSES), .W(ACC_W)) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .start_i (am_start_q),
    .values_i(cmp_vals),
    .done_o  (am_done),
    .idx_o   (am_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      pix_q          <= 1'b0;
      vld_q          <= 1'b0;
      am_start_q     <= 1'b0;
      acc_q          <= '0;
      output_test_q  <= '0;
      digit_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      am_start_q     <= 1'b0;
      result_valid_q <= 1'b0;
      vld_q          <= 1'b0;
      // Weight row arrives one cycle after its address; pixels are binary so it is add-or-skip.
      if (vld_q && pix_q) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          acc_q[i] <= acc_q[i] + ACC_W'($signed(weights_in[i]));
      end
      case (state_q)
        IDLE: begin
          if (start_pixel) begin
            acc_q   <= '0;
            count_q <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM, DRAIN: begin
          if (start_pixel) begin
            acc_q   <= '0;
            count_q <= '0;
            state_q <= ACCUM;
          end else if (state_q == DRAIN) begin
            am_start_q <= 1'b1;
            state_q    <= ARGMAX;
          end else if (start_stream) begin
            pix_q   <= pixel;
            vld_q   <= 1'b1;
            count_q <= count_q + 10'd1;
            if (count_q == LAST_PIX) state_q <= DRAIN;
          end
        end
        ARGMAX: begin
          // Results are registered on entry to DONE so they are visible during the DONE cycle.
          if (am_done) begin
            output_test_q  <= out_conv;
            digit_q        <= class_to_digit(am_idx);
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr      = count_q;
  assign output_test  = output_test_q;
  assign digit        = digit_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != IDLE);

endmodule
